// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    // Number of source cycles clk_p stays high in one period: ceil(n/2).
    function automatic logic [MAX_W:0] hi_len(input logic [MAX_W-1:0] n);
        return ({1'b0, n} + (MAX_W + 1)'(1)) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_neg_retime.sv
// Falling-edge retiming flop producing the half-cycle-delayed copy of clk_p.
module clk_div_neg_retime (
    input  logic clk,
    input  logic rstn,
    input  logic clk_p,
    output logic clk_n
);

    logic clk_n_q;
    logic clk_n_d;

    always_comb begin
        clk_n_d = clk_p;
    end

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_n_q <= 1'b0;
        end else begin
            clk_n_q <= clk_n_d;
        end
    end

    assign clk_n = clk_n_q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty integer clock divider with glitch-free
// divisor updates at period boundaries, run/stop control and a period tick.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = 4,
    parameter int DEF_DIV = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic             clk_div,
    output logic             tick,
    output logic             busy
);

    localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] MIN_N = DIV_W'(2);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             clk_p_q, clk_p_d;
    logic             err_q, err_d;
    logic             clk_n;
    logic             last;
    logic             apply;
    logic             load_ok;
    logic [MAX_W:0]   cnt_ext;

    always_comb begin
        last    = (cnt_q == active_q - ONE);
        apply   = pending_q && ((state_q == IDLE) || last);
        load_ok = div_load && (div_val >= MIN_N);

        state_d = state_q;
        case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN:  if (!en) state_d = last ? IDLE : STOP;
            STOP: begin
                if (en) begin
                    state_d = RUN;
                end else if (last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new period (or leaving IDLE) always starts from count 0.
        cnt_d = '0;
        if ((state_q != IDLE) && (state_d != IDLE) && !last) begin
            cnt_d = cnt_q + ONE;
        end

        active_d  = apply ? shadow_q : active_q;
        shadow_d  = load_ok ? div_val : shadow_q;
        pending_d = load_ok || (pending_q && !apply);
        err_d     = div_load && (div_val < MIN_N);

        // STOP keeps the waveform running so the current high phase is never cut.
        cnt_ext = (MAX_W + 1)'(cnt_d);
        clk_p_d = (state_d != IDLE) && (cnt_ext < hi_len(MAX_W'(active_q)));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            active_q  <= DEF_N;
            shadow_q  <= DEF_N;
            pending_q <= 1'b0;
            clk_p_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            clk_p_q   <= clk_p_d;
            err_q     <= err_d;
        end
    end

    clk_div_neg_retime u_neg_retime (
        .clk   (clk),
        .rstn  (rstn),
        .clk_p (clk_p_q),
        .clk_n (clk_n)
    );

    // Odd divisors AND in the half-cycle-late copy to trim half a cycle of high time.
    assign clk_div = active_q[0] ? (clk_p_q & clk_n) : clk_p_q;
    assign busy    = (state_q != IDLE);
    assign tick    = busy && last;
    assign div_ack = apply;
    assign div_err = err_q;

endmodule
